// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - two-player paddle position controller with debounced buttons
// Positions move one STEP per detected vsync rising edge, clamped to 0..MAXPOS.

module paddle_ctrl #(
   parameter int SCREEN_H  = 480,
   parameter int PADDLE_H  = 64,
   parameter int STEP      = 4,
   parameter int DB_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       p1_up,
   input  logic       p1_dn,
   input  logic       p2_up,
   input  logic       p2_dn,
   output logic [9:0] paddle1_next,
   output logic [9:0] paddle2_next,
   output logic       frame_tick
);

   localparam logic [9:0]  MAXPOS  = 10'(SCREEN_H - PADDLE_H);
   localparam logic [9:0]  INITPOS = 10'((SCREEN_H - PADDLE_H) / 2);
   localparam logic [9:0]  STEP_L  = 10'(STEP);
   localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

   logic [3:0]  raw;
   logic [3:0]  sync1;
   logic [3:0]  sync2;
   logic [3:0]  stable;
   logic [19:0] cnt [4];
   logic        vs_q;
   logic        vs_valid;

   // Bit order: 0 = p1_up, 1 = p1_dn, 2 = p2_up, 3 = p2_dn
   assign raw = {p2_dn, p2_up, p1_dn, p1_up};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 20'd1;
            end
         end
      end
   end

   // vs_valid masks the first cycle after reset so a vsync already high at
   // release is not mistaken for a rising edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_q       <= 1'b0;
         vs_valid   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vs_q       <= vsync;
         vs_valid   <= 1'b1;
         frame_tick <= vsync & ~vs_q & vs_valid;
      end
   end

   function automatic logic [9:0] next_pos(input logic [9:0] pos, input logic up, input logic dn);
      logic [10:0] sum;
      logic [9:0]  res;
      sum = {1'b0, pos} + {1'b0, STEP_L};
      res = pos;
      if (up && !dn) begin
         res = (pos < STEP_L) ? 10'd0 : pos - STEP_L;
      end else if (dn && !up) begin
         res = (sum > {1'b0, MAXPOS}) ? MAXPOS : sum[9:0];
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         paddle1_next <= INITPOS;
         paddle2_next <= INITPOS;
      end else if (frame_tick) begin
         paddle1_next <= next_pos(paddle1_next, stable[0], stable[1]);
         paddle2_next <= next_pos(paddle2_next, stable[2], stable[3]);
      end
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - scoreboard bench for paddle_ctrl
// Stimulus queues the expected positions per frame; a monitor checks them after each tick.

module tb_paddle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       vsync = 1'b0;
   logic       p1_up = 1'b0;
   logic       p1_dn = 1'b0;
   logic       p2_up = 1'b0;
   logic       p2_dn = 1'b0;
   logic [9:0] paddle1_next;
   logic [9:0] paddle2_next;
   logic       frame_tick;

   typedef struct {
      int p1;
      int p2;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   paddle_ctrl #(.DB_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .vsync        (vsync),
      .p1_up        (p1_up),
      .p1_dn        (p1_dn),
      .p2_up        (p2_up),
      .p2_dn        (p2_dn),
      .paddle1_next (paddle1_next),
      .paddle2_next (paddle2_next),
      .frame_tick   (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic frame(input int p1, input int p2, input int high);
      exp_t e;
      e.p1 = p1;
      e.p2 = p2;
      exp_q.push_back(e);
      @(negedge clk) vsync = 1'b1;
      repeat (high) @(negedge clk);
      vsync = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_p1"}, paddle1_next, 208);
      check({tag, "_p2"}, paddle2_next, 208);
      check({tag, "_tick"}, frame_tick, 0);
   endtask

   // Monitor: each tick pops one expectation, checked on the following cycle.
   initial begin
      exp_t e;
      bit   pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            check("frame_p1", paddle1_next, e.p1);
            check("frame_p2", paddle2_next, e.p2);
            check("tick_width", frame_tick, 0);
            pend = 1'b0;
         end else if (frame_tick) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_tick actual=1 required=0");
            end else begin
               e = exp_q.pop_front();
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e1;
      int e2;

      // Reset held 5 cycles, then 3 idle frames
      repeat (5) begin
         @(negedge clk);
         check_reset_state("init_rst");
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      repeat (3) frame(208, 208, 3);

      // p1_up held: 208 -> 204 -> 200 -> 196
      p1_up = 1'b1;
      repeat (10) @(negedge clk);
      frame(204, 208, 3);
      frame(200, 208, 3);
      frame(196, 208, 3);

      // Reset mid-frame with p1_up still held
      @(negedge clk) vsync = 1'b1;
      #2 reset = 1'b0;
      #1 check_reset_state("mid_rst");
      @(negedge clk) vsync = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_reset_state("mid_rst_hold");
      end
      reset = 1'b1;
      frame(208, 208, 3);
      frame(204, 208, 3);
      p1_up = 1'b0;
      repeat (10) @(negedge clk);

      // vsync already high at release must not tick until it toggles
      @(negedge clk) begin
         reset = 1'b0;
         vsync = 1'b1;
      end
      #1 check_reset_state("vs_high_rst");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      vsync = 1'b0;
      repeat (3) @(negedge clk);
      frame(208, 208, 2);

      // 3-cycle glitch on p1_dn is filtered out
      @(negedge clk) p1_dn = 1'b1;
      repeat (3) @(negedge clk);
      p1_dn = 1'b0;
      repeat (10) @(negedge clk);
      frame(208, 208, 3);
      frame(208, 208, 3);

      // p1 up+dn cancels; p2 up moves independently
      p1_up = 1'b1;
      p1_dn = 1'b1;
      p2_up = 1'b1;
      repeat (10) @(negedge clk);
      frame(208, 204, 3);
      frame(208, 200, 3);
      p1_up = 1'b0;
      p1_dn = 1'b0;
      p2_up = 1'b0;
      repeat (10) @(negedge clk);

      // 60 frames: p1 saturates at 0, p2 at 416
      p1_up = 1'b1;
      p2_dn = 1'b1;
      repeat (10) @(negedge clk);
      e1 = 208;
      e2 = 200;
      for (int i = 0; i < 60; i++) begin
         e1 = e1 - 4;
         if (e1 < 0) e1 = 0;
         e2 = e2 + 4;
         if (e2 > 416) e2 = 416;
         frame(e1, e2, 2);
      end
      p1_up = 1'b0;
      p2_dn = 1'b0;
      repeat (10) @(negedge clk);
      check("final_p1", paddle1_next, 0);
      check("final_p2", paddle2_next, 416);
      check("pending_frames", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 Parameter SCREEN_H, default 480, visible lines per frame.
REQ-002 Parameter PADDLE_H, default 64, paddle height in lines.
REQ-003 Parameter STEP, default 4, lines moved per frame tick.
REQ-004 Parameter DB_CYCLES, default 50000, debounce stability window in clk cycles (range 2..2^20-1).
REQ-005 clk  input  1  pixel clock; all state rising-edge.
REQ-006 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-007 vsync  input  1  vertical sync from the sync generator, synchronous to clk, active-high.
REQ-008 p1_up, p1_dn, p2_up, p2_dn  input  1 each  raw asynchronous push-buttons, active-high.
REQ-009 paddle1_next  output  10  player-1 paddle top line, registered.
REQ-010 paddle2_next  output  10  player-2 paddle top line, registered.
REQ-011 frame_tick  output  1  single-cycle pulse marking each detected vsync rising edge.

Function
REQ-012 Derived constants: MAXPOS = SCREEN_H - PADDLE_H (416 default); INITPOS = MAXPOS/2 (208 default).
REQ-013 Each button passes through a dedicated 2-flop synchronizer; raw-to-synced latency is 2 cycles.
REQ-014 Per button, debounce: stable level register plus counter; counter clears on any cycle where synced == stable, else increments.
REQ-015 Stable level takes the synced value, and counter clears, on the cycle the counter would reach DB_CYCLES; pulses shorter than DB_CYCLES synced cycles never change stable level.
REQ-016 vsync is registered once (vs_q); frame_tick = vsync & ~vs_q, registered so it is high exactly one cycle after the rising edge is sampled.
REQ-017 vsync held high any number of cycles produces exactly one frame_tick.
REQ-018 Positions update only on the cycle frame_tick is high; new value visible on outputs the following cycle.
REQ-019 Up only (stable): pos <= (pos < STEP) ? 0 : pos - STEP.
REQ-020 Down only (stable): pos <= (pos + STEP > MAXPOS) ? MAXPOS : pos + STEP; sum computed 11 bits wide, no wrap.
REQ-021 Up and down both stable-high, or neither: position unchanged.
REQ-022 The two players are fully independent; simultaneous moves of both on one tick are both applied.
REQ-023 Outputs never leave 0..MAXPOS under any input sequence.

Reset
REQ-024 While reset is low: paddle1_next = paddle2_next = INITPOS, frame_tick = 0, vs_q = 0, all synchronizer, stable and counter registers = 0, asynchronously.
REQ-025 First frame_tick after reset release requires a vsync rising edge sampled after release; vsync already high at release yields no tick until it goes low then high.
REQ-026 Reset asserted mid-debounce or mid-frame discards all pending state; no movement is applied on release.

Verification (bench overrides DB_CYCLES = 4; other parameters default)
REQ-027 Reset low 5 cycles, release, 3 vsync pulses, no buttons -> both outputs 208 throughout, 3 single-cycle frame_tick pulses.
REQ-028 p1_up held high, 3 vsync pulses after debounce settles -> paddle1_next 208->204->200->196, paddle2_next 208.
REQ-029 p1_dn high for 3 clk cycles then low, followed by vsync pulses -> no frame moves paddle1; stays 208.
REQ-030 p2_dn held across 60 frames -> paddle2_next saturates at 416 and stays; p1_up held 60 frames -> paddle1_next reaches 0 and stays.
REQ-031 p1_up and p1_dn both held, p2_up held, 2 vsync pulses -> paddle1_next 208, paddle2_next 200.
REQ-032 After paddle1_next = 196, reset pulsed low mid-frame with p1_up still held -> outputs 208 same cycle as assertion; after release no movement until debounce re-settles and next vsync edge.
